// File: rtl/execute.sv
// execute: RV32I execute stage with ALU, branch resolution and the exe_mem pipeline register
module execute (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] rs1_id_exe,
    input  logic [31:0] rs2_id_exe,
    input  logic [31:0] PC_id_exe,
    input  logic [31:0] imm_id_exe,
    input  logic [4:0]  write_reg_id_exe,
    input  logic [2:0]  funct3_id_exe,
    input  logic        funct7_5_id_exe,
    input  logic        ctrl_branch_id_exe,
    input  logic        ctrl_mem_read_id_exe,
    input  logic        ctrl_mem_to_reg_id_exe,
    input  logic        ctrl_mem_write_id_exe,
    input  logic        ctrl_alu_src_id_exe,
    input  logic        ctrl_write_reg_id_exe,
    input  logic [1:0]  ctrl_alu_op_id_exe,
    output logic [31:0] alu_result_exe_mem,
    output logic [31:0] rs2_exe_mem,
    output logic [4:0]  write_reg_exe_mem,
    output logic [2:0]  funct3_exe_mem,
    output logic        ctrl_mem_read_exe_mem,
    output logic        ctrl_mem_to_reg_exe_mem,
    output logic        ctrl_mem_write_exe_mem,
    output logic        ctrl_write_reg_exe_mem,
    output logic        branch_taken_exe_if,
    output logic [31:0] branch_target_exe_if
);
    logic [31:0] w_a, w_b, w_alu;
    logic [4:0]  w_sh;
    logic        w_cond, w_eq, w_lt, w_ltu;
    assign w_a  = rs1_id_exe;
    assign w_b  = ctrl_alu_src_id_exe ? imm_id_exe : rs2_id_exe;
    assign w_sh = w_b[4:0];
    // branch comparisons always use the register operands, never the immediate
    assign w_eq  = rs1_id_exe == rs2_id_exe;
    assign w_lt  = $signed(rs1_id_exe) < $signed(rs2_id_exe);
    assign w_ltu = rs1_id_exe < rs2_id_exe;
    // ALU: load/store adds, branch subtracts, R/I-type decode funct3 (I-type ignores funct7_5 except for shifts right)
    always_comb begin
        w_alu = w_a + w_b;
        if (!ctrl_alu_op_id_exe[1]) begin
            w_alu = ctrl_alu_op_id_exe[0] ? w_a - w_b : w_a + w_b;
        end else begin
            case (funct3_id_exe)
                3'b000: w_alu = (!ctrl_alu_op_id_exe[0] && funct7_5_id_exe) ? w_a - w_b : w_a + w_b;
                3'b001: w_alu = w_a << w_sh;
                3'b010: w_alu = {31'b0, $signed(w_a) < $signed(w_b)};
                3'b011: w_alu = {31'b0, w_a < w_b};
                3'b100: w_alu = w_a ^ w_b;
                3'b101: w_alu = funct7_5_id_exe ? $unsigned($signed(w_a) >>> w_sh) : w_a >> w_sh;
                3'b110: w_alu = w_a | w_b;
                default: w_alu = w_a & w_b;
            endcase
        end
    end
    // branch condition by funct3; 010/011 are not branch encodings and never take
    always_comb begin
        w_cond = 1'b0;
        case (funct3_id_exe)
            3'b000: w_cond = w_eq;
            3'b001: w_cond = !w_eq;
            3'b100: w_cond = w_lt;
            3'b101: w_cond = !w_lt;
            3'b110: w_cond = w_ltu;
            3'b111: w_cond = !w_ltu;
            default: w_cond = 1'b0;
        endcase
    end
    // exe_mem register: reset and flush both insert a zero bubble, stall holds everything
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            alu_result_exe_mem      <= '0;
            rs2_exe_mem             <= '0;
            write_reg_exe_mem       <= '0;
            funct3_exe_mem          <= '0;
            ctrl_mem_read_exe_mem   <= 1'b0;
            ctrl_mem_to_reg_exe_mem <= 1'b0;
            ctrl_mem_write_exe_mem  <= 1'b0;
            ctrl_write_reg_exe_mem  <= 1'b0;
            branch_taken_exe_if     <= 1'b0;
            branch_target_exe_if    <= '0;
        end else if (!stall) begin
            alu_result_exe_mem      <= w_alu;
            rs2_exe_mem             <= rs2_id_exe;
            write_reg_exe_mem       <= write_reg_id_exe;
            funct3_exe_mem          <= funct3_id_exe;
            ctrl_mem_read_exe_mem   <= ctrl_mem_read_id_exe;
            ctrl_mem_to_reg_exe_mem <= ctrl_mem_to_reg_id_exe;
            ctrl_mem_write_exe_mem  <= ctrl_mem_write_id_exe;
            ctrl_write_reg_exe_mem  <= ctrl_write_reg_id_exe && (write_reg_id_exe != 5'd0);
            branch_taken_exe_if     <= ctrl_branch_id_exe && w_cond;
            branch_target_exe_if    <= PC_id_exe + imm_id_exe;
        end
    end
endmodule

// File: tb/tb_execute.sv
// tb_execute: scoreboard bench for the execute stage using directed vectors
module tb_execute;
    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic [31:0] rs1, rs2, pc, imm;
    logic [4:0]  wr;
    logic [2:0]  f3;
    logic        f7, br, mr, m2r, mw, src, cw;
    logic [1:0]  op;
    logic [31:0] o_alu, o_rs2, o_tgt;
    logic [4:0]  o_wr;
    logic [2:0]  o_f3;
    logic        o_mr, o_m2r, o_mw, o_cw, o_tk;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] rs2;
        logic [4:0]  wr;
        logic [2:0]  f3;
        logic        mr, m2r, mw, cw, tk;
        logic [31:0] tgt;
    } exp_t;

    exp_t q[$];
    exp_t last;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    execute dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .rs1_id_exe(rs1), .rs2_id_exe(rs2), .PC_id_exe(pc), .imm_id_exe(imm),
        .write_reg_id_exe(wr), .funct3_id_exe(f3), .funct7_5_id_exe(f7),
        .ctrl_branch_id_exe(br), .ctrl_mem_read_id_exe(mr), .ctrl_mem_to_reg_id_exe(m2r),
        .ctrl_mem_write_id_exe(mw), .ctrl_alu_src_id_exe(src), .ctrl_write_reg_id_exe(cw),
        .ctrl_alu_op_id_exe(op),
        .alu_result_exe_mem(o_alu), .rs2_exe_mem(o_rs2), .write_reg_exe_mem(o_wr),
        .funct3_exe_mem(o_f3), .ctrl_mem_read_exe_mem(o_mr), .ctrl_mem_to_reg_exe_mem(o_m2r),
        .ctrl_mem_write_exe_mem(o_mw), .ctrl_write_reg_exe_mem(o_cw),
        .branch_taken_exe_if(o_tk), .branch_target_exe_if(o_tgt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor: the DUT presents a new exe_mem word after every edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk("alu", o_alu, e.alu);
                chk("rs2", o_rs2, e.rs2);
                chk("wr", {27'b0, o_wr}, {27'b0, e.wr});
                chk("f3", {29'b0, o_f3}, {29'b0, e.f3});
                chk("mr", {31'b0, o_mr}, {31'b0, e.mr});
                chk("m2r", {31'b0, o_m2r}, {31'b0, e.m2r});
                chk("mw", {31'b0, o_mw}, {31'b0, e.mw});
                chk("cw", {31'b0, o_cw}, {31'b0, e.cw});
                chk("taken", {31'b0, o_tk}, {31'b0, e.tk});
                chk("target", o_tgt, e.tgt);
            end
        end
    end

    // push the expected exe_mem word for the current inputs, then advance one cycle
    task automatic step(input logic [31:0] ea, input logic et);
        exp_t e;
        if (rst || flush) e = '0;
        else if (stall) e = last;
        else e = '{ea, rs2, wr, f3, mr, m2r, mw, cw && (wr != 5'd0), et, pc + imm};
        last = e;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; stall = 0; flush = 0;
        rs1 = 0; rs2 = 0; pc = 0; imm = 0; wr = 0; f3 = 0; f7 = 0;
        br = 0; mr = 0; m2r = 0; mw = 0; src = 0; cw = 0; op = 0;
    endtask

    initial begin
        idle();
        last = '0;
        rst = 1; rs1 = 32'h1234; rs2 = 32'h55; pc = 32'h40; imm = 4; wr = 9; cw = 1; br = 1; mr = 1;
        step(0, 0);
        idle(); rst = 0;
        rs1 = 5; rs2 = 7; op = 2'b10; f3 = 3'b000; f7 = 1; wr = 3; cw = 1;
        step(32'hFFFFFFFE, 0);
        f7 = 0;
        step(32'd12, 0);
        idle(); rs1 = 32'h80000000; imm = 32'h404; src = 1; op = 2'b11; f3 = 3'b101; f7 = 1; wr = 4; cw = 1;
        step(32'hF8000000, 0);
        f3 = 3'b000; imm = 1;
        step(32'h80000001, 0);
        idle(); rs1 = 32'hFFFFFFFF; rs2 = 1; op = 2'b10; f3 = 3'b010; wr = 5; cw = 1;
        step(32'd1, 0);
        f3 = 3'b011;
        step(32'd0, 0);
        idle(); rs1 = 32'hFFFFFFFF; rs2 = 1; br = 1; pc = 32'h100; imm = 32'hFFFFFFF0; op = 2'b01; f3 = 3'b100;
        step(32'hFFFFFFFE, 1);
        f3 = 3'b110;
        step(32'hFFFFFFFE, 0);
        f3 = 3'b111;
        step(32'hFFFFFFFE, 1);
        f3 = 3'b010;
        step(32'hFFFFFFFE, 0);
        idle(); rs1 = 9; rs2 = 9; imm = 32'h20; src = 1; br = 1; pc = 32'h100; op = 2'b01; f3 = 3'b000;
        step(32'hFFFFFFE9, 1);
        idle(); rs1 = 32'h1000; imm = 8; src = 1; wr = 0; cw = 1; mr = 1; m2r = 1; f3 = 3'b010;
        step(32'h1008, 0);
        idle(); rs1 = 32'h2000; rs2 = 32'hDEADBEEF; imm = 32'hFFFFFFFC; src = 1; mw = 1; f3 = 3'b010;
        step(32'h1FFC, 0);
        idle(); rs1 = 1; rs2 = 2; br = 1; pc = 32'h200; imm = 16; op = 2'b01; f3 = 3'b001; wr = 6; mr = 1;
        step(32'hFFFFFFFF, 1);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            br = 0; rs1 = 32'(i * 17 + 3); rs2 = 32'(i + 100); pc = 32'(i * 4); wr = 5'(i + 10);
            f3 = 3'(i); mw = 1; mr = 0; cw = 1;
            step(0, 0);
        end
        flush = 1;
        step(0, 0);
        idle(); rs1 = 1; rs2 = 31; op = 2'b10; f3 = 3'b001; wr = 8; cw = 1; pc = 32'h300; imm = 32'h10;
        step(32'h80000000, 0);
        rst = 1; stall = 1; rs1 = 32'hF0F0; rs2 = 32'h0FF0; f3 = 3'b100;
        step(0, 0);
        idle(); rs1 = 32'h80000000; rs2 = 4; op = 2'b10; f3 = 3'b101; wr = 12; cw = 1; mm();
        step(32'h08000000, 0);
        rs1 = 32'hF0F0; rs2 = 32'h0FF0; f3 = 3'b100;
        step(32'h0000FF00, 0);
        f3 = 3'b110;
        step(32'h0000FFF0, 0);
        f3 = 3'b111;
        step(32'h000000F0, 0);
        idle();
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    task automatic mm();
        m2r = 1;
    endtask
endmodule

// File: doc/execute.md
EXECUTE -- requirements
Module: execute

Interface
REQ-001 SHALL have clk  input  1  pipeline clock, all state updates on rising edge.
REQ-002 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have stall  input  1  hold all exe_mem registers.
REQ-004 SHALL have flush  input  1  replace next exe_mem contents with a bubble.
REQ-005 SHALL have rs1_id_exe, rs2_id_exe, PC_id_exe, imm_id_exe  input  32 each  operands, PC and immediate from decode.
REQ-006 SHALL have write_reg_id_exe  input  5; funct3_id_exe  input  3; funct7_5_id_exe  input  1.
REQ-007 SHALL have ctrl_branch/mem_read/mem_to_reg/mem_write/alu_src/write_reg_id_exe  input  1 each; ctrl_alu_op_id_exe  input  2.
REQ-008 SHALL have alu_result_exe_mem  output  32  registered ALU result.
REQ-009 SHALL have rs2_exe_mem  output  32  registered store data.
REQ-010 SHALL have write_reg_exe_mem  output  5; funct3_exe_mem  output  3.
REQ-011 SHALL have ctrl_mem_read/mem_to_reg/mem_write/write_reg_exe_mem  output  1 each.
REQ-012 SHALL have branch_taken_exe_if  output  1 and branch_target_exe_if  output  32, both registered.

Function
REQ-013 Operand A SHALL be rs1_id_exe; operand B SHALL be imm_id_exe when alu_src=1, else rs2_id_exe.
REQ-014 alu_op 00 (load/store) SHALL select ADD; alu_op 01 (branch) SHALL select SUB.
REQ-015 alu_op 10 (R-type) SHALL decode funct3: 000 ADD/SUB (SUB if funct7_5), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA (SRA if funct7_5), 110 OR, 111 AND.
REQ-016 alu_op 11 (I-type ALU) SHALL decode as REQ-015, except funct3=000 is always ADD; funct7_5 is honoured only for funct3=101.
REQ-017 Arithmetic SHALL be 32-bit modulo 2^32, no overflow flag; shift amount SHALL be B[4:0]; SLT signed, SLTU unsigned, result 0 or 1 zero-extended.
REQ-018 Branch condition by funct3: 000 A==B, 001 A!=B, 100 signed A<B, 101 signed A>=B, 110 unsigned A<B, 111 unsigned A>=B; 010/011 SHALL never take; always compared on rs1/rs2 regardless of alu_src.
REQ-019 branch_taken_exe_if SHALL be ctrl_branch AND condition, registered, 1-cycle latency.
REQ-020 branch_target_exe_if SHALL be PC_id_exe + imm_id_exe (mod 2^32), registered every non-stalled, non-flushed cycle regardless of taken.
REQ-021 rs2_exe_mem, write_reg_exe_mem, funct3_exe_mem and ctrl_mem_read/mem_to_reg/mem_write SHALL register the inputs unchanged.
REQ-022 ctrl_write_reg_exe_mem SHALL be forced 0 when write_reg_id_exe==0 (x0 never written).
REQ-023 Each edge, priority SHALL be rst > flush > stall > normal load.
REQ-024 Flush SHALL load zero into every exe_mem output, including data fields.
REQ-025 Stall SHALL hold every exe_mem output at its prior value; branch_taken SHALL also hold (upstream hazard logic must not stall on a taken branch).
REQ-026 Latency SHALL be exactly one cycle input-to-output; no combinational input-to-output path.

Reset
REQ-027 With rst=1 at a rising edge, all outputs SHALL be 0 on the next cycle, overriding stall and flush.
REQ-028 rst mid-stream SHALL discard the in-flight instruction; first post-reset load SHALL be the inputs present at the first edge with rst=0.

Verification
REQ-029 R-type SUB: rs1=5, rs2=7, alu_op=10, funct3=000, funct7_5=1 -> alu_result=0xFFFFFFFE next cycle.
REQ-030 I-type SRAI: rs1=0x80000000, imm=0x404, alu_src=1, alu_op=11, funct3=101, funct7_5=1 -> alu_result=0xF8000000; same with alu_op=11, funct3=000, funct7_5=1, imm=1 -> ADD result 0x80000001.
REQ-031 BLT vs BLTU: rs1=0xFFFFFFFF, rs2=1, branch=1, PC=0x100, imm=0xFFFFFFF0 -> funct3=100 taken=1, target=0xF0; funct3=110 taken=0.
REQ-032 x0 guard: write_reg_id_exe=0, ctrl_write_reg=1 -> ctrl_write_reg_exe_mem=0.
REQ-033 Stall 3 cycles with changing inputs -> outputs frozen; flush+stall same edge -> all outputs 0.
REQ-034 rst asserted with flush=0, stall=1 and nonzero outputs -> all outputs 0 next cycle.
